// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared fetch types, FSM encoding and constants
package typePack;

    typedef logic [31:0] instruction_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    localparam instruction_t NOP = 32'h0000_0013;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// rtl/inst_fetch_fifo.sv - prefetch FIFO with flop storage, clear, push, pop and occupancy
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is fine when the same cycle pops the slot it overwrites.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - sequential instruction fetch with credit-limited requests and redirect flush
module inst_fetch
    import typePack::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    output logic         IMEM_REQ_VALID,
    input  logic         IMEM_REQ_READY,
    output logic [31:0]  IMEM_REQ_ADDR,
    input  logic         IMEM_RSP_VALID,
    input  logic [31:0]  IMEM_RSP_DATA,
    output instruction_t INST,
    output logic [31:0]  INST_PC,
    output logic         INST_VALID,
    input  logic         INST_READY,
    input  logic         REDIRECT,
    input  logic [31:0]  REDIRECT_PC
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, drop_q, drop_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full, fifo_push, fifo_clear;
    logic [63:0]   fifo_data;
    logic          credit, req_fire;

    // Credits look only at registered occupancy so INST_READY never reaches the request path.
    assign credit = !fifo_full &&
                    (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));

    assign IMEM_REQ_VALID = (state_q == FETCH) && credit;
    assign IMEM_REQ_ADDR  = fpc_q;
    assign req_fire       = IMEM_REQ_VALID && IMEM_REQ_READY;

    assign INST_VALID = !fifo_empty;
    assign INST       = fifo_data[63:32];
    assign INST_PC    = fifo_data[31:0];

    always_comb begin
        state_d       = state_q;
        fpc_d         = fpc_q;
        rpc_d         = rpc_q;
        drop_d        = drop_q;
        fifo_push     = 1'b0;
        fifo_clear    = 1'b0;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(IMEM_RSP_VALID);

        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (req_fire) fpc_d = fpc_q + 32'd4;
                if (IMEM_RSP_VALID) begin
                    fifo_push = 1'b1;
                    rpc_d     = rpc_q + 32'd4;
                end
            end
            DRAIN: begin
                if (IMEM_RSP_VALID) begin
                    drop_d = drop_q - CW'(1);
                    if (drop_q == CW'(1)) state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Whatever is still in flight after this edge belongs to the old stream.
        if (REDIRECT) begin
            fifo_clear = 1'b1;
            fifo_push  = 1'b0;
            fpc_d      = align_word(REDIRECT_PC);
            rpc_d      = align_word(REDIRECT_PC);
            drop_d     = outstanding_d;
            state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            fpc_q         <= RESET_PC;
            rpc_q         <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            rpc_q         <= rpc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (CLOCK),
        .rst_ni      (RESET_N),
        .clear_i     (fifo_clear),
        .push_i      (fifo_push),
        .push_data_i ({IMEM_RSP_DATA, rpc_q}),
        .pop_i       (INST_READY),
        .data_o      (fifo_data),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with a latency-programmable memory model
module tb_inst_fetch;
    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IMEM_REQ_VALID;
    logic        IMEM_REQ_READY = 1'b0;
    logic [31:0] IMEM_REQ_ADDR;
    logic        IMEM_RSP_VALID = 1'b0;
    logic [31:0] IMEM_RSP_DATA = '0;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_VALID;
    logic        INST_READY = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = '0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];
    int          checks = 0, errors = 0, cyc = 0, lat = 1, consumed = 0, req_cnt = 0;
    logic [31:0] exp_fpc = 32'h0;

    inst_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .CLOCK          (CLOCK),
        .RESET_N        (RESET_N),
        .IMEM_REQ_VALID (IMEM_REQ_VALID),
        .IMEM_REQ_READY (IMEM_REQ_READY),
        .IMEM_REQ_ADDR  (IMEM_REQ_ADDR),
        .IMEM_RSP_VALID (IMEM_RSP_VALID),
        .IMEM_RSP_DATA  (IMEM_RSP_DATA),
        .INST           (INST),
        .INST_PC        (INST_PC),
        .INST_VALID     (INST_VALID),
        .INST_READY     (INST_READY),
        .REDIRECT       (REDIRECT),
        .REDIRECT_PC    (REDIRECT_PC)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        REDIRECT    = 1'b1;
        REDIRECT_PC = pc;
        step();
        REDIRECT    = 1'b0;
    endtask

    task automatic expect_pcs(input logic [31:0] start, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(4 * i);
            exp_q.push_back({pc | 32'h13, pc});
        end
    endtask

    task automatic wait_consumed(input int n);
        int target;
        target     = consumed + n;
        INST_READY = 1'b1;
        for (int i = 0; i < 300 && consumed < target; i++) step();
        INST_READY = 1'b0;
        check("consume_count", 32'(consumed), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(IMEM_REQ_VALID), 32'd0);
        check({tag, "_inst_valid"}, 32'(INST_VALID), 32'd0);
        check({tag, "_req_addr"}, IMEM_REQ_ADDR, 32'h0);
        check({tag, "_inst"}, INST, 32'h0);
        check({tag, "_inst_pc"}, INST_PC, 32'h0);
    endtask

    // Memory: in-order responses, 'lat' cycles after acceptance, data = addr | 0x13.
    initial forever begin
        @(negedge CLOCK);
        cyc++;
        if (!RESET_N) begin
            pend.delete();
            IMEM_RSP_VALID = 1'b0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                IMEM_RSP_VALID = 1'b1;
                IMEM_RSP_DATA  = pend[0].addr | 32'h13;
                void'(pend.pop_front());
            end else begin
                IMEM_RSP_VALID = 1'b0;
            end
            if (IMEM_REQ_VALID && IMEM_REQ_READY)
                pend.push_back('{addr: IMEM_REQ_ADDR, due: cyc + lat});
        end
    end

    // Request address monitor.
    initial forever begin
        @(negedge CLOCK);
        if (!RESET_N) begin
            exp_fpc = 32'h0;
            req_cnt = 0;
        end else begin
            if (IMEM_REQ_VALID && IMEM_REQ_READY) begin
                check("req_addr", IMEM_REQ_ADDR, exp_fpc);
                exp_fpc = exp_fpc + 32'd4;
                req_cnt++;
            end
            if (REDIRECT) exp_fpc = {REDIRECT_PC[31:2], 2'b00};
        end
    end

    // Instruction scoreboard monitor.
    initial forever begin
        logic [63:0] e;
        @(negedge CLOCK);
        if (RESET_N && INST_VALID && INST_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst actual_pc=%h expected=none", INST_PC);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", INST_PC, e[31:0]);
                check("inst_data", INST, e[63:32]);
            end
            consumed++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check_reset_outputs("reset");

        // Reset release, IDLE cycle, then a request held through a stall.
        RESET_N = 1'b1;
        check("idle_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
        step();
        check("first_req_valid", 32'(IMEM_REQ_VALID), 32'd1);
        check("first_req_addr", IMEM_REQ_ADDR, 32'h0);
        step();
        check("stall_req_valid", 32'(IMEM_REQ_VALID), 32'd1);
        check("stall_req_addr", IMEM_REQ_ADDR, 32'h0);
        IMEM_REQ_READY = 1'b1;

        // Backpressure: only FIFO_DEPTH requests go out.
        repeat (10) step();
        check("bp_req_count", 32'(req_cnt), 32'd2);
        check("bp_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
        check("bp_inst_valid", 32'(INST_VALID), 32'd1);
        check("bp_inst_pc", INST_PC, 32'h0);

        expect_pcs(32'h0, 8);
        wait_consumed(8);

        // Redirect with two requests in flight on a 3-cycle memory.
        repeat (12) step();
        lat = 3;
        redirect(32'h40);
        step();
        step();
        redirect(32'h100);
        check("drain_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
        check("drain_inst_valid", 32'(INST_VALID), 32'd0);
        expect_pcs(32'h100, 2);
        wait_consumed(2);

        // Redirect in the same cycle as a request acceptance and a response.
        repeat (12) step();
        lat = 1;
        redirect(32'h300);
        step();
        redirect(32'h500);
        expect_pcs(32'h500, 3);
        wait_consumed(3);

        // Misaligned redirect and address wrap.
        repeat (12) step();
        redirect(32'h203);
        check("misalign_req_addr", IMEM_REQ_ADDR, 32'h200);
        expect_pcs(32'h200, 2);
        wait_consumed(2);
        repeat (12) step();
        redirect(32'hFFFF_FFFC);
        check("wrap_req_addr0", IMEM_REQ_ADDR, 32'hFFFF_FFFC);
        step();
        check("wrap_req_addr1", IMEM_REQ_ADDR, 32'h0);
        expect_pcs(32'hFFFF_FFFC, 3);
        wait_consumed(3);

        // Reset asserted while draining.
        repeat (12) step();
        lat = 3;
        repeat (4) step();
        redirect(32'h700);
        step();
        step();
        redirect(32'h800);
        step();
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midreset");
        step();
        RESET_N = 1'b1;
        lat = 1;
        check("restart_idle_valid", 32'(IMEM_REQ_VALID), 32'd0);
        step();
        check("restart_req_valid", 32'(IMEM_REQ_VALID), 32'd1);
        check("restart_req_addr", IMEM_REQ_ADDR, 32'h0);
        expect_pcs(32'h0, 3);
        wait_consumed(3);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
